bp_table_ctrl: RTL and testbench

//  Controller for the 2-bit branch-history counter table, held in a single-port sync-read RAM.
//  - Sequences the post-reset clear sweep.
//  - Arbitrates the RAM port between fetch-stage lookups and ROB outcome updates.
//  - Buffers updates in a small FIFO and applies each one as a saturating read-modify-write.

---
 rtl/bp_table_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_bp_table_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_table_ctrl.sv
// ---------------------------------------------------------------------------
// bp_table_ctrl
//   Controller for a table of 2-bit saturating branch-history counters kept
//   in an external single-port RAM with synchronous read.
//   - After reset, a clear sweep writes INIT_STATE to every entry.
//   - Fetch-stage lookups and queued commit updates share the RAM port.
//   - Commit updates go into a small FIFO. Each one is applied as a
//     read-modify-write: issue the read, wait for the data, then write back.
//
// Ports
//   clk_in, rst_in      clock; asynchronous active-low reset
//   rdy_in              global ready; when low, all state is frozen
//   lk_req/lk_pc        lookup request; lk_ready is the same-cycle accept
//   lk_valid/lk_taken   registered prediction, one cycle after the accept
//   upd_valid/upd_pc/upd_taken   committed branch outcome
//   upd_full            update FIFO is full
//   drop_cnt            number of updates lost to overflow (saturating)
//   init_busy           clear sweep in progress
//   ram_*               RAM port (combinational strobes); ram_rdata is
//                       valid the cycle after a read
// ---------------------------------------------------------------------------
module bp_table_ctrl #(
   parameter int         IDX_W      = 7,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [1:0] INIT_STATE = 2'b01
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             lk_req,
   input  logic [31:0]      lk_pc,
   output logic             lk_ready,
   output logic             lk_valid,
   output logic             lk_taken,
   input  logic             upd_valid,
   input  logic [31:0]      upd_pc,
   input  logic             upd_taken,
   output logic             upd_full,
   output logic [7:0]       drop_cnt,
   output logic             init_busy,
   output logic             ram_en,
   output logic             ram_we,
   output logic [IDX_W-1:0] ram_addr,
   output logic [1:0]       ram_wdata,
   input  logic [1:0]       ram_rdata
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_UPD_RD, ST_UPD_WR} state_t;

   state_t             state_reg, state_next;
   logic [IDX_W-1:0]   sweep_ptr_reg;
   logic [IDX_W-1:0]   fifo_idx_reg [FIFO_DEPTH];
   logic               fifo_tkn_reg [FIFO_DEPTH];
   logic [PTR_W-1:0]   head_reg, tail_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [7:0]         drop_cnt_reg;
   logic               lk_valid_reg;
   logic [1:0]         new_val_reg, new_val_next;

   logic               fifo_full, fifo_empty, push, pop;
   logic [IDX_W-1:0]   head_idx;
   logic               head_tkn;
   logic               lk_ready_c, ram_en_c, ram_we_c;
   logic [IDX_W-1:0]   ram_addr_c;
   logic [1:0]         ram_wdata_c;

   // The index uses only pc[IDX_W+1:2]. The remaining pc bits are
   // intentionally unused.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{lk_pc[31:IDX_W+2], lk_pc[1:0],
                             upd_pc[31:IDX_W+2], upd_pc[1:0]};

   assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count_reg == '0);
   assign head_idx   = fifo_idx_reg[head_reg];
   assign head_tkn   = fifo_tkn_reg[head_reg];

   // Saturating counter step computed from the RAM data that arrives
   // in UPD_RD.
   always_comb begin
      new_val_next = ram_rdata;
      if (head_tkn) begin
         if (ram_rdata != 2'b11) new_val_next = ram_rdata + 2'd1;
      end else begin
         if (ram_rdata != 2'b00) new_val_next = ram_rdata - 2'd1;
      end
   end

   // Next-state logic and RAM port arbitration.
   always_comb begin
      state_next  = state_reg;
      lk_ready_c  = 1'b0;
      ram_en_c    = 1'b0;
      ram_we_c    = 1'b0;
      ram_addr_c  = '0;
      ram_wdata_c = '0;
      pop         = 1'b0;
      if (rdy_in) begin
         unique case (state_reg)
            ST_INIT: begin
               ram_en_c    = 1'b1;
               ram_we_c    = 1'b1;
               ram_addr_c  = sweep_ptr_reg;
               ram_wdata_c = INIT_STATE;
               if (sweep_ptr_reg == {IDX_W{1'b1}}) state_next = ST_IDLE;
            end
            ST_IDLE: begin
               // A full FIFO takes priority over lookups, so commits can
               // never be starved indefinitely.
               if (fifo_full) begin
                  ram_en_c   = 1'b1;
                  ram_addr_c = head_idx;
                  state_next = ST_UPD_RD;
               end else if (lk_req) begin
                  lk_ready_c = 1'b1;
                  ram_en_c   = 1'b1;
                  ram_addr_c = lk_pc[IDX_W+1:2];
               end else if (!fifo_empty) begin
                  ram_en_c   = 1'b1;
                  ram_addr_c = head_idx;
                  state_next = ST_UPD_RD;
               end
            end
            ST_UPD_RD: state_next = ST_UPD_WR;
            ST_UPD_WR: begin
               ram_en_c    = 1'b1;
               ram_we_c    = 1'b1;
               ram_addr_c  = head_idx;
               ram_wdata_c = new_val_reg;
               pop         = 1'b1;
               state_next  = ST_IDLE;
            end
            default: state_next = ST_INIT;
         endcase
      end
   end

   // A push is still accepted when the FIFO is full, as long as a pop
   // frees an entry in the same cycle.
   assign push = upd_valid && rdy_in && (!fifo_full || pop);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_reg     <= ST_INIT;
         sweep_ptr_reg <= '0;
         head_reg      <= '0;
         tail_reg      <= '0;
         count_reg     <= '0;
         drop_cnt_reg  <= '0;
         lk_valid_reg  <= 1'b0;
         new_val_reg   <= '0;
      end else if (rdy_in) begin
         state_reg    <= state_next;
         lk_valid_reg <= lk_ready_c;
         if (state_reg == ST_INIT) sweep_ptr_reg <= sweep_ptr_reg + IDX_W'(1);
         if (state_reg == ST_UPD_RD) new_val_reg <= new_val_next;
         if (push) tail_reg <= tail_reg + PTR_W'(1);
         if (pop)  head_reg <= head_reg + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
         if (upd_valid && !push && drop_cnt_reg != 8'hFF)
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
   end

   // FIFO payload storage.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_idx_reg[i] <= '0;
            fifo_tkn_reg[i] <= 1'b0;
         end
      end else if (push) begin
         fifo_idx_reg[tail_reg] <= upd_pc[IDX_W+1:2];
         fifo_tkn_reg[tail_reg] <= upd_taken;
      end
   end

   // Combinational outputs are forced low while reset is asserted, so the
   // RAM sees no strobe during reset.
   assign lk_ready  = lk_ready_c & rst_in;
   assign ram_en    = ram_en_c & rst_in;
   assign ram_we    = ram_we_c & rst_in;
   assign ram_addr  = ram_addr_c & {IDX_W{rst_in}};
   assign ram_wdata = ram_wdata_c & {2{rst_in}};

   assign lk_valid  = lk_valid_reg;
   assign lk_taken  = lk_valid_reg & ram_rdata[1];
   assign upd_full  = fifo_full;
   assign drop_cnt  = drop_cnt_reg;
   assign init_busy = (state_reg == ST_INIT);

endmodule

// File: tb/tb_bp_table_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bp_table_ctrl
//   Self-checking bench for bp_table_ctrl. A behavioural RAM is attached to
//   the DUT. A transaction-level model (a counter array, a queue of pending
//   updates, and an RMW phase counter) predicts every output on each
//   falling edge. Directed scenarios pin the model to hand-computed values;
//   a randomized phase then exercises the design against the model.
// ---------------------------------------------------------------------------
module tb_bp_table_ctrl;
   localparam int         IDX_W  = 7;
   localparam int         DEPTH  = 4;
   localparam int         N      = 128;
   localparam logic [1:0] INIT_V = 2'b01;

   logic             clk_in = 1'b0;
   logic             rst_in = 1'b0;
   logic             rdy_in = 1'b1;
   logic             lk_req = 1'b0;
   logic [31:0]      lk_pc = '0;
   logic             upd_valid = 1'b0;
   logic [31:0]      upd_pc = '0;
   logic             upd_taken = 1'b0;
   logic             lk_ready, lk_valid, lk_taken, upd_full, init_busy;
   logic [7:0]       drop_cnt;
   logic             ram_en, ram_we;
   logic [IDX_W-1:0] ram_addr;
   logic [1:0]       ram_wdata;
   logic [1:0]       ram_rdata;

   bp_table_ctrl #(.IDX_W(IDX_W), .FIFO_DEPTH(DEPTH), .INIT_STATE(INIT_V)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .lk_req(lk_req), .lk_pc(lk_pc), .lk_ready(lk_ready),
      .lk_valid(lk_valid), .lk_taken(lk_taken),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_full(upd_full), .drop_cnt(drop_cnt), .init_busy(init_busy),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk_in = ~clk_in;

   // Single-port RAM with synchronous read. The read data holds until the
   // next read.
   logic [1:0] mem [N];
   always @(posedge clk_in) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {int idx; bit tkn;} upd_t;
   upd_t m_q[$];
   bit   m_sweep = 1'b1;
   int   m_ptr = 0;
   int   m_phase = 0;      // 0 none, 1 read issued, 2 write due
   int   m_drops = 0;
   bit   m_lkv = 1'b0;
   bit   m_lkt = 1'b0;
   int   ref_tbl [N];

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % N);
   endfunction

   function automatic int sat(input int v, input bit t);
      if (t) return (v >= 3) ? 3 : v + 1;
      return (v <= 0) ? 0 : v - 1;
   endfunction

   always @(negedge clk_in) begin : cmp
      bit e_en, e_we, e_rdy, pop, push;
      int e_addr, e_wd;
      if (!rst_in) begin
         m_sweep = 1'b1; m_ptr = 0; m_phase = 0; m_q.delete();
         m_drops = 0; m_lkv = 1'b0; m_lkt = 1'b0;
         chk("rst_ram_en", ram_en, 0);
         chk("rst_ram_we", ram_we, 0);
         chk("rst_ram_addr", ram_addr, 0);
         chk("rst_ram_wdata", ram_wdata, 0);
         chk("rst_lk_ready", lk_ready, 0);
         chk("rst_lk_valid", lk_valid, 0);
         chk("rst_lk_taken", lk_taken, 0);
         chk("rst_init_busy", init_busy, 1);
         chk("rst_drop_cnt", drop_cnt, 0);
         chk("rst_upd_full", upd_full, 0);
      end else begin
         e_en = 0; e_we = 0; e_rdy = 0; e_addr = 0; e_wd = 0;
         if (rdy_in) begin
            if (m_sweep) begin
               e_en = 1; e_we = 1; e_addr = m_ptr; e_wd = INIT_V;
            end else if (m_phase == 1) begin
               e_en = 0;
            end else if (m_phase == 2) begin
               e_en = 1; e_we = 1; e_addr = m_q[0].idx;
               e_wd = sat(ref_tbl[m_q[0].idx], m_q[0].tkn);
            end else if (m_q.size() == DEPTH) begin
               e_en = 1; e_addr = m_q[0].idx;
            end else if (lk_req) begin
               e_rdy = 1; e_en = 1; e_addr = idx_of(lk_pc);
            end else if (m_q.size() > 0) begin
               e_en = 1; e_addr = m_q[0].idx;
            end
         end
         chk("ram_en", ram_en, e_en);
         chk("lk_ready", lk_ready, e_rdy);
         if (e_en) begin
            chk("ram_we", ram_we, e_we);
            chk("ram_addr", ram_addr, e_addr);
         end
         if (e_we) chk("ram_wdata", ram_wdata, e_wd);
         chk("lk_valid", lk_valid, m_lkv);
         chk("lk_taken", lk_taken, m_lkv & m_lkt);
         chk("upd_full", upd_full, m_q.size() == DEPTH);
         chk("drop_cnt", drop_cnt, m_drops);
         chk("init_busy", init_busy, m_sweep);
         if (rdy_in) begin
            pop  = !m_sweep && m_phase == 2;
            push = upd_valid && (m_q.size() < DEPTH || pop);
            m_lkv = e_rdy;
            if (e_rdy) m_lkt = ((ref_tbl[e_addr] >> 1) & 1) != 0;
            if (m_sweep) begin
               ref_tbl[m_ptr] = INIT_V;
               if (m_ptr == N - 1) m_sweep = 1'b0;
               m_ptr = (m_ptr + 1) % N;
            end else if (m_phase == 2) begin
               ref_tbl[m_q[0].idx] = e_wd;
               m_phase = 0;
            end else if (m_phase == 1) begin
               m_phase = 2;
            end else if (e_en && !e_rdy) begin
               m_phase = 1;
            end
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back('{idx_of(upd_pc), upd_taken});
            else if (upd_valid && m_drops < 255) m_drops++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Push one update, then let it drain. Returns the number of RAM strobes
   // seen while it drains.
   task automatic push_upd(input logic [31:0] pc, input bit t, output int ens);
      upd_valid = 1'b1; upd_pc = pc; upd_taken = t;
      tick();
      upd_valid = 1'b0;
      ens = 0;
      repeat (4) begin
         #3;
         if (ram_en) ens++;
         tick();
      end
   endtask

   initial begin
      int cnt, bad, ens;
      // Reset, then interrupt the sweep at pointer 50.
      rst_in = 1'b0; rdy_in = 1'b1;
      repeat (3) tick();
      rst_in = 1'b1;
      cnt = 0;
      while (!(ram_en && ram_we && ram_addr == 7'd50) && cnt < 500) begin
         tick(); cnt++;
      end
      chk("reach_ptr50", cnt < 500, 1);
      rst_in = 1'b0;
      #1;
      chk("async_rst_ram_en", ram_en, 0);
      chk("async_rst_init_busy", init_busy, 1);
      tick(); tick();
      lk_req = 1'b1; lk_pc = 32'h0000_1004;   // must be ignored during the sweep
      rst_in = 1'b1;
      @(negedge clk_in);
      chk("restart_addr0", ram_addr, 0);
      cnt = 0;
      while (init_busy && cnt < 300) begin
         cnt++;
         @(negedge clk_in);
      end
      chk("init_cycles", cnt, 128);
      tick();
      lk_req = 1'b0;
      bad = 0;
      for (int i = 0; i < N; i++) if (mem[i] != INIT_V || ref_tbl[i] != 1) bad++;
      chk("swept_entries_bad", bad, 0);

      // Lookup 0x1004 -> entry 1, weakly not-taken.
      tick();
      lk_req = 1'b1; lk_pc = 32'h0000_1004;
      #3;
      chk("lk1_ready", lk_ready, 1);
      chk("lk1_addr", ram_addr, 1);
      tick();
      lk_req = 1'b0;
      #3;
      chk("lk1_valid", lk_valid, 1);
      chk("lk1_taken", lk_taken, 0);
      tick();

      // Two taken updates saturate entry 1 at 3.
      push_upd(32'h0000_1004, 1'b1, ens);
      chk("rmw_ram_cycles", ens, 2);
      push_upd(32'h0000_1004, 1'b1, ens);
      chk("entry1_after2", mem[1], 3);
      chk("model_entry1", ref_tbl[1], 3);
      lk_req = 1'b1; lk_pc = 32'h0000_1004;
      tick();
      lk_req = 1'b0;
      #3;
      chk("lk2_taken", lk_taken, 1);
      tick();
      push_upd(32'h0000_1004, 1'b1, ens);
      chk("entry1_sat_hi", mem[1], 3);

      // Three not-taken updates saturate entry 2 at 0.
      repeat (3) push_upd(32'h0000_2008, 1'b0, ens);
      chk("entry2_sat_lo", mem[2], 0);

      // Burst of 5 updates while lookups are requested continuously.
      lk_req = 1'b1; lk_pc = 32'h0000_1004;
      for (int k = 0; k < 5; k++) begin
         upd_valid = 1'b1; upd_pc = 32'h0000_3000 + 32'(4 * k); upd_taken = k[0];
         if (k == 4) begin
            #3;
            chk("burst_full", upd_full, 1);
            chk("burst_forced_rd_ready", lk_ready, 0);
            chk("burst_forced_rd_en", ram_en, 1);
         end
         tick();
      end
      upd_valid = 1'b0;
      chk("burst_drop_cnt", drop_cnt, 1);
      #3; chk("burst_rd_ready", lk_ready, 0); tick();
      #3; chk("burst_wr_ready", lk_ready, 0); tick();
      #3; chk("burst_idle_ready", lk_ready, 1); tick();
      lk_req = 1'b0;
      repeat (12) tick();
      chk("burst_drained_full", upd_full, 0);

      // Freeze for 10 cycles in the middle of UPD_RD.
      upd_valid = 1'b1; upd_pc = 32'h0000_2008; upd_taken = 1'b1;
      tick();
      upd_valid = 1'b0;
      tick();
      rdy_in = 1'b0;
      cnt = 0;
      repeat (10) begin
         #3;
         if (ram_en) cnt++;
         tick();
      end
      chk("freeze_ram_strobes", cnt, 0);
      rdy_in = 1'b1;
      repeat (4) tick();
      chk("freeze_rmw_result", mem[2], 1);

      // Randomized traffic against the model.
      repeat (3000) begin
         rdy_in    = ($urandom_range(0, 7) != 0);
         lk_req    = $urandom_range(0, 1) != 0;
         lk_pc     = $urandom;
         upd_valid = ($urandom_range(0, 9) < 4);
         upd_pc    = $urandom;
         upd_taken = $urandom_range(0, 1) != 0;
         tick();
      end
      rdy_in = 1'b1; lk_req = 1'b0; upd_valid = 1'b0;
      repeat (20) tick();
      for (int i = 0; i < N; i++) chk($sformatf("final_tbl[%0d]", i), mem[i], ref_tbl[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
